// File: rtl/bus_arbiter.sv
// Shares one memory bus between the instruction-fetch and data ports.
// Data wins by default; a streak counter keeps fetch from starving, and a flush drops stale fetch results.
module bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  input  logic        fetch_flush,
  output logic [31:0] fetch_data,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_strobe,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strobe,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strobe_q, strobe_d;
  logic        fack_q, fack_d;
  logic        dack_q, dack_d;
  logic [31:0] fdata_q, fdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic        fetch_win_s, data_win_s;
  logic        grant_fetch_s, grant_data_s;

  // Winner is chosen from the raw requests; a port in its own ack cycle then forfeits the grant.
  always_comb begin
    fetch_win_s = 1'b0;
    data_win_s  = 1'b0;
    if (fetch_req && data_req) begin
      if (streak_q == LIMIT) begin
        fetch_win_s = 1'b1;
      end else begin
        data_win_s = 1'b1;
      end
    end else begin
      fetch_win_s = fetch_req;
      data_win_s  = data_req;
    end
  end

  assign grant_fetch_s = (state_q == ST_IDLE) && fetch_win_s && !fack_q;
  assign grant_data_s  = (state_q == ST_IDLE) && data_win_s && !dack_q;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    fack_d   = 1'b0;
    dack_d   = 1'b0;
    fdata_d  = fdata_q;
    drdata_d = drdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_fetch_s) begin
          state_d  = ST_FETCH;
          valid_d  = 1'b1;
          addr_d   = fetch_address;
          write_d  = 1'b0;
          strobe_d = 4'hF;
          streak_d = 4'd0;
        end else if (grant_data_s) begin
          state_d  = ST_DATA;
          valid_d  = 1'b1;
          addr_d   = data_address;
          write_d  = data_write;
          wdata_d  = data_wdata;
          strobe_d = data_strobe;
          if (fetch_req) begin
            streak_d = (streak_q < LIMIT) ? streak_q + 4'd1 : streak_q;
          end else begin
            streak_d = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // A flush on the completion edge itself still suppresses the ack.
        if (mem_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          fdata_d = mem_rdata;
          fack_d  = !(drop_q || fetch_flush);
          drop_d  = 1'b0;
        end else begin
          drop_d = drop_q || fetch_flush;
        end
      end
      ST_DATA: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          dack_d  = 1'b1;
          if (!write_q) begin
            drdata_d = mem_rdata;
          end else begin
            drdata_d = drdata_q;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      streak_q <= 4'd0;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      strobe_q <= 4'd0;
      fack_q   <= 1'b0;
      dack_q   <= 1'b0;
      fdata_q  <= 32'd0;
      drdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      fack_q   <= fack_d;
      dack_q   <= dack_d;
      fdata_q  <= fdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign mem_valid   = valid_q;
  assign mem_address = addr_q;
  assign mem_write   = write_q;
  assign mem_wdata   = wdata_q;
  assign mem_strobe  = strobe_q;
  assign fetch_ack   = fack_q;
  assign data_ack    = dack_q;
  assign fetch_data  = fdata_q;
  assign data_rdata  = drdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_address;
  logic        fetch_flush;
  logic [31:0] fetch_data;
  logic        fetch_ack;
  logic        data_req;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_wdata;
  logic [3:0]  data_strobe;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_flush(fetch_flush),
    .fetch_data(fetch_data), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_write(data_write), .data_address(data_address),
    .data_wdata(data_wdata), .data_strobe(data_strobe), .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_strobe(mem_strobe), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic set_idle();
    fetch_req = 1'b0; fetch_address = 32'd0; fetch_flush = 1'b0;
    data_req = 1'b0; data_write = 1'b0; data_address = 32'd0;
    data_wdata = 32'd0; data_strobe = 4'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Holds both requests with a zero-wait bus and records which port owns each new bus transfer.
  task automatic grant_order(input int n, output string s);
    logic prev;
    int   cyc;
    s = "";
    prev = mem_valid;
    cyc = 0;
    fetch_req = 1'b1; fetch_address = 32'hF000;
    data_req = 1'b1; data_address = 32'hD000; data_write = 1'b0; mem_ready = 1'b1;
    while (s.len() < n && cyc < 200) begin
      step();
      cyc++;
      if (mem_valid && !prev) begin
        if (mem_address == 32'hF000) s = {s, "F"};
        else s = {s, "D"};
      end
      prev = mem_valid;
    end
    fetch_req = 1'b0;
    data_req = 1'b0;
    chk("grant_order_timeout", 32'(cyc >= 200), 32'd0);
  endtask

  typedef struct {
    logic        freq;  logic [31:0] faddr;
    logic        dreq;  logic        dwr;   logic [31:0] daddr; logic [31:0] dwd; logic [3:0] dstb;
    logic        rdy;   logic [31:0] rdata; logic        flush;
    logic        e_valid; logic [31:0] e_addr; logic e_wr; logic [3:0] e_stb; logic [31:0] e_wd;
    logic        e_fack;  logic        e_dack; logic [31:0] e_fdata; logic [31:0] e_drd;
  } vec_t;
  vec_t vt [10];

  // Transaction-level reference: who owns the bus and the latched transfer, not a state encoding.
  int          m_owner;  // 0 = bus free, 1 = fetch, 2 = data
  logic [31:0] m_addr, m_wd, m_fdata, m_drd;
  logic        m_wr;
  logic [3:0]  m_stb;
  int          m_streak;
  bit          m_drop, m_fack, m_dack;

  task automatic model_reset();
    m_owner = 0; m_addr = 32'd0; m_wd = 32'd0; m_fdata = 32'd0; m_drd = 32'd0;
    m_wr = 1'b0; m_stb = 4'd0; m_streak = 0; m_drop = 0; m_fack = 0; m_dack = 0;
  endtask

  task automatic model_step();
    bit nf, nd;
    int pick;
    nf = 0;
    nd = 0;
    if (m_owner == 0) begin
      pick = 0;
      if (fetch_req && data_req) pick = (m_streak == LIMIT) ? 1 : 2;
      else if (fetch_req) pick = 1;
      else if (data_req) pick = 2;
      if (pick == 1 && m_fack) pick = 0;
      if (pick == 2 && m_dack) pick = 0;
      if (pick == 1) begin
        m_owner = 1; m_addr = fetch_address; m_wr = 1'b0; m_stb = 4'hF; m_streak = 0;
      end else if (pick == 2) begin
        m_owner = 2; m_addr = data_address; m_wr = data_write; m_wd = data_wdata; m_stb = data_strobe;
        if (fetch_req) m_streak = (m_streak < LIMIT) ? m_streak + 1 : m_streak;
        else m_streak = 0;
      end
    end else begin
      if (m_owner == 1 && fetch_flush) m_drop = 1;
      if (mem_ready) begin
        if (m_owner == 1) begin
          m_fdata = mem_rdata;
          nf = !m_drop;
          m_drop = 0;
        end else begin
          if (!m_wr) m_drd = mem_rdata;
          nd = 1;
        end
        m_owner = 0;
      end
    end
    m_fack = nf;
    m_dack = nd;
  endtask

  initial begin
    string order;
    int    extra;

    set_idle();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    step();
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_strobe", 32'(mem_strobe), 32'd0);
    chk("rst_fack", 32'(fetch_ack), 32'd0);
    chk("rst_dack", 32'(data_ack), 32'd0);
    chk("rst_fdata", fetch_data, 32'd0);
    chk("rst_drdata", data_rdata, 32'd0);

    // Directed vectors: single fetch with masked ack cycle, data read, data write, then a fetch.
    vt[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hA5A50001, 1'b0,
              1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h11112222, 1'b0,
              1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h11112222, 32'h0};
    vt[2] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h33333333, 1'b0,
              1'b0, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h11112222, 32'h0};
    vt[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h77, 4'h5, 1'b0, 32'h44444444, 1'b0,
              1'b1, 32'h300, 1'b0, 4'h5, 32'h77, 1'b0, 1'b0, 32'h11112222, 32'h0};
    vt[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h77, 4'h5, 1'b1, 32'hCAFE0003, 1'b0,
              1'b0, 32'h300, 1'b0, 4'h5, 32'h77, 1'b0, 1'b1, 32'h11112222, 32'hCAFE0003};
    vt[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 32'h12345678, 4'hC, 1'b1, 32'h55555555, 1'b0,
              1'b0, 32'h300, 1'b0, 4'h5, 32'h77, 1'b0, 1'b0, 32'h11112222, 32'hCAFE0003};
    vt[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 32'h12345678, 4'hC, 1'b1, 32'h55555555, 1'b0,
              1'b1, 32'h400, 1'b1, 4'hC, 32'h12345678, 1'b0, 1'b0, 32'h11112222, 32'hCAFE0003};
    vt[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h99999999, 1'b1,
              1'b0, 32'h400, 1'b1, 4'hC, 32'h12345678, 1'b0, 1'b1, 32'h11112222, 32'hCAFE0003};
    vt[8] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0,
              1'b1, 32'h200, 1'b0, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'h11112222, 32'hCAFE0003};
    vt[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BAD0000, 1'b0,
              1'b0, 32'h200, 1'b0, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h0BAD0000, 32'hCAFE0003};
    for (int i = 0; i < 10; i++) begin
      fetch_req = vt[i].freq; fetch_address = vt[i].faddr; fetch_flush = vt[i].flush;
      data_req = vt[i].dreq; data_write = vt[i].dwr; data_address = vt[i].daddr;
      data_wdata = vt[i].dwd; data_strobe = vt[i].dstb; mem_ready = vt[i].rdy; mem_rdata = vt[i].rdata;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(mem_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_addr", i), mem_address, vt[i].e_addr);
      chk($sformatf("vec%0d_write", i), 32'(mem_write), 32'(vt[i].e_wr));
      chk($sformatf("vec%0d_strobe", i), 32'(mem_strobe), 32'(vt[i].e_stb));
      chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].e_wd);
      chk($sformatf("vec%0d_fack", i), 32'(fetch_ack), 32'(vt[i].e_fack));
      chk($sformatf("vec%0d_dack", i), 32'(data_ack), 32'(vt[i].e_dack));
      chk($sformatf("vec%0d_fdata", i), fetch_data, vt[i].e_fdata);
      chk($sformatf("vec%0d_drdata", i), data_rdata, vt[i].e_drd);
    end

    // Starvation guard: both ports held continuously.
    apply_reset();
    grant_order(10, order);
    chk_str("starve_order", order, "DDDDFDDDDF");

    // Wait states on a data write: bus outputs frozen until mem_ready.
    apply_reset();
    data_req = 1'b1; data_write = 1'b1; data_address = 32'h2000;
    data_wdata = 32'hDEADBEEF; data_strobe = 4'h3; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      data_req = 1'b0; data_address = 32'h0; data_wdata = 32'h0; data_strobe = 4'h0; data_write = 1'b0;
      chk($sformatf("ws%0d_valid", k), 32'(mem_valid), 32'd1);
      chk($sformatf("ws%0d_addr", k), mem_address, 32'h2000);
      chk($sformatf("ws%0d_wdata", k), mem_wdata, 32'hDEADBEEF);
      chk($sformatf("ws%0d_strobe", k), 32'(mem_strobe), 32'h3);
      chk($sformatf("ws%0d_write", k), 32'(mem_write), 32'd1);
      chk($sformatf("ws%0d_dack", k), 32'(data_ack), 32'd0);
    end
    mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
    step();
    chk("ws_done_valid", 32'(mem_valid), 32'd0);
    chk("ws_done_dack", 32'(data_ack), 32'd1);
    chk("ws_done_rdata", data_rdata, 32'd0);
    mem_ready = 1'b0;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (data_ack) extra++;
    end
    chk("ws_single_ack", 32'(extra), 32'd0);

    // Flush mid-fetch: transfer completes, ack suppressed, next fetch acknowledged.
    apply_reset();
    fetch_req = 1'b1; fetch_address = 32'h80; mem_ready = 1'b0;
    step();
    chk("fl_grant_addr", mem_address, 32'h80);
    fetch_req = 1'b0; fetch_flush = 1'b1;
    step();
    fetch_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h600DF00D;
    step();
    chk("fl_done_valid", 32'(mem_valid), 32'd0);
    chk("fl_done_fack", 32'(fetch_ack), 32'd0);
    chk("fl_done_fdata", fetch_data, 32'h600DF00D);
    step();
    chk("fl_quiet_fack", 32'(fetch_ack), 32'd0);
    fetch_req = 1'b1; fetch_address = 32'h40;
    step();
    chk("fl_next_valid", 32'(mem_valid), 32'd1);
    chk("fl_next_addr", mem_address, 32'h40);
    fetch_req = 1'b0; mem_rdata = 32'h40404040;
    step();
    chk("fl_next_fack", 32'(fetch_ack), 32'd1);
    chk("fl_next_fdata", fetch_data, 32'h40404040);

    // Reset mid-data-transfer with a built-up streak.
    apply_reset();
    grant_order(3, order);
    chk_str("rm_pre_order", order, "DDD");
    step();
    step();
    fetch_req = 1'b1; data_req = 1'b1; mem_ready = 1'b0;
    step();
    chk("rm_data_valid", 32'(mem_valid), 32'd1);
    chk("rm_data_addr", mem_address, 32'hD000);
    fetch_req = 1'b0; data_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rm_async_valid", 32'(mem_valid), 32'd0);
    chk("rm_async_addr", mem_address, 32'd0);
    chk("rm_async_strobe", 32'(mem_strobe), 32'd0);
    chk("rm_async_fdata", fetch_data, 32'd0);
    chk("rm_async_drdata", data_rdata, 32'd0);
    #2;
    reset = 1'b0;
    step();
    grant_order(5, order);
    chk_str("rm_post_order", order, "DDDDF");

    // Randomized traffic against the reference model.
    apply_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
      end
      fetch_req = ($urandom_range(0, 9) < 32'd7);
      fetch_address = $urandom;
      fetch_flush = ($urandom_range(0, 19) < 32'd3);
      data_req = ($urandom_range(0, 9) < 32'd6);
      data_write = ($urandom_range(0, 1) == 32'd1);
      data_address = $urandom;
      data_wdata = $urandom;
      data_strobe = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 1) == 32'd1);
      mem_rdata = $urandom;
      model_step();
      step();
      chk("rnd_valid", 32'(mem_valid), 32'(m_owner != 0));
      chk("rnd_fack", 32'(fetch_ack), 32'(m_fack));
      chk("rnd_dack", 32'(data_ack), 32'(m_dack));
      chk("rnd_fdata", fetch_data, m_fdata);
      chk("rnd_drdata", data_rdata, m_drd);
      if (m_owner != 0) begin
        chk("rnd_addr", mem_address, m_addr);
        chk("rnd_write", 32'(mem_write), 32'(m_wr));
        chk("rnd_strobe", 32'(mem_strobe), 32'(m_stb));
        if (m_wr) chk("rnd_wdata", mem_wdata, m_wd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
